stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Two-button stopwatch controller for the lab board, built above the cell library (DFF, MUX21, gates).
//   Synchronises and debounces raw push-buttons, prescales CLK to a 10 ms tick, and keeps a 4-digit
//   BCD time SS.hh (00.00-59.99) with start/stop, lap-freeze and clear.
//   Feeds the 7-segment scan/decode stage downstream; consumes raw button pins upstream.
// PARAMETERS
//   TICK_DIV  1000000  CLK cycles per 10 ms tick (100 MHz board); must be >= 2
//   DB_CNT    500000   consecutive stable synced cycles required to accept a new button level; >= 1
// PORTS
//   CLK      in   1   system clock, all state on rising edge
//   RESET    in   1   asynchronous, active-low reset (RESET=0 resets)
//   BTN_SS   in   1   raw start/stop button, active-high, asynchronous, bouncy
//   BTN_LC   in   1   raw lap/clear button, active-high, asynchronous, bouncy
//   DIGITS   out  16  {sec_tens, sec_units, tenths, hundredths}, 4 bits BCD each
//   RUNNING  out  1   1 while time is advancing (RUN or LAP state)
//   LAP      out  1   1 while DIGITS shows the frozen lap value
//   TICK     out  1   one-cycle pulse per 10 ms period while RUNNING
// BEHAVIOUR
//   Reset: DIGITS=16'h0000, RUNNING=0, LAP=0, TICK=0; FSM=IDLE; prescaler, time, lap_reg,
//     debounce counters, synchronisers and stable levels all 0. Release takes effect at next CLK edge.
//   Input path per button: 2-FF synchroniser -> debouncer. Counter clears whenever synced == stable;
//     increments otherwise; at DB_CNT consecutive mismatches stable <= synced, counter clears.
//     Press event = 1-cycle pulse on stable 0->1. Release (1->0) produces no event.
//     Raw edge to event: 2 + DB_CNT cycles (+/-1 for async input sampling).
//   Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP; TICK=1 in the cycle count==TICK_DIV-1, then wraps to 0.
//     Held (not cleared) in STOP; cleared on entering IDLE.
//   Time: on TICK, hundredths +1; carry chain hundredths 9->0, tenths 9->0, sec_units 9->0,
//     sec_tens 5->0; 59.99 wraps to 00.00, RUNNING stays 1. No digit ever exceeds its max.
//   Time is registered: DIGITS reflects increment in the cycle after TICK.
//   DIGITS = LAP ? lap_reg : time (registered output, no combinational path from buttons).
//   FSM (transitions on the cycle after the press event):
//     IDLE: SS -> RUN.              LC ignored.
//     RUN : SS -> STOP.             LC -> LAP, lap_reg <= current time (same-cycle tick included).
//     LAP : SS -> STOP (LAP=0).     LC -> RUN (LAP=0, live time shown). Counting never pauses.
//     STOP: SS -> RUN (resume).     LC -> IDLE, time<=0, prescaler<=0.
//   Simultaneous SS and LC events in one cycle: SS wins, LC discarded.
//   Events arriving while a transition is in progress are evaluated against the new state next cycle.
//   Async reset mid-run: all state zero immediately, no partial tick or event survives.
// TESTING (TICK_DIV=4, DB_CNT=3)
//   Hold RESET=0, wiggle both buttons 50 cycles -> DIGITS=16'h0000, RUNNING=0, LAP=0, TICK never 1.
//   BTN_SS toggled every cycle 8 cycles then low -> no event, FSM stays IDLE; clean 10-cycle press -> RUNNING=1.
//   Run from 00.00, count 10 TICK pulses -> DIGITS=16'h0010; continue to 16'h5999, next tick -> 16'h0000.
//   LC at 16'h0123 -> DIGITS frozen 16'h0123, LAP=1 while TICK continues; LC again -> live value, LAP=0.
//   RUN, SS -> STOP, DIGITS constant over 40 cycles; SS -> resumes same value; SS then LC -> 16'h0000, IDLE.
//   STOP with SS and LC pressed same cycle -> RUN, time kept; assert RESET=0 mid-run -> all outputs 0 at once.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch: synchronised/debounced buttons, 10 ms prescaler, BCD SS.hh time with lap freeze.
// Each button lane runs 2-FF sync -> debounce -> one-cycle press pulse on a stable rising level.

module stopwatch_btn #(
  parameter int DB_CNT = 500000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic press
);
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        // DB_CNT-th consecutive mismatch: accept the new level, pulse only on press
        stable <= s2;
        cnt    <= '0;
        press  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int DB_CNT   = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTN_SS,
  input  logic        BTN_LC,
  output logic [15:0] DIGITS,
  output logic        RUNNING,
  output logic        LAP,
  output logic        TICK
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

  state_t          state, st_n;
  logic [PW-1:0]   pre, pre_n, pre_adv;
  logic [15:0]     tm, tm_n, tm_adv;
  logic [15:0]     lapv, lapv_n;
  logic [1:0]      press;
  logic            ev_ss, ev_lc, run_c, tick_c;

  stopwatch_btn #(.DB_CNT(DB_CNT)) u_btn [1:0] (
    .CLK   (CLK),
    .RESET (RESET),
    .raw   ({BTN_LC, BTN_SS}),
    .press (press)
  );

  assign ev_ss = press[0];
  assign ev_lc = press[1];

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd9) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    run_c   = (state == S_RUN) || (state == S_LAP);
    tick_c  = run_c && (pre == PW'(TICK_DIV - 1));
    pre_adv = tick_c ? '0 : pre + 1'b1;
    tm_adv  = tick_c ? bcd_inc(tm) : tm;
  end

  // Counting continues through the transition cycle; lap captures the post-tick value.
  always_comb begin
    st_n   = state;
    pre_n  = pre;
    tm_n   = tm;
    lapv_n = lapv;
    if (run_c) begin
      pre_n = pre_adv;
      tm_n  = tm_adv;
    end
    case (state)
      S_IDLE: if (ev_ss) st_n = S_RUN;
      S_RUN: begin
        if (ev_ss) st_n = S_STOP;
        else if (ev_lc) begin
          st_n   = S_LAP;
          lapv_n = tm_adv;
        end
      end
      S_LAP: begin
        if (ev_ss)      st_n = S_STOP;
        else if (ev_lc) st_n = S_RUN;
      end
      S_STOP: begin
        if (ev_ss) st_n = S_RUN;
        else if (ev_lc) begin
          st_n  = S_IDLE;
          tm_n  = '0;
          pre_n = '0;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      pre     <= '0;
      tm      <= '0;
      lapv    <= '0;
      DIGITS  <= '0;
      RUNNING <= 1'b0;
      LAP     <= 1'b0;
    end else begin
      state   <= st_n;
      pre     <= pre_n;
      tm      <= tm_n;
      lapv    <= lapv_n;
      DIGITS  <= (st_n == S_LAP) ? lapv_n : tm_n;
      RUNNING <= (st_n == S_RUN) || (st_n == S_LAP);
      LAP     <= (st_n == S_LAP);
    end
  end

  assign TICK = RUNNING && (pre == PW'(TICK_DIV - 1));
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic, checked every cycle
// against a centisecond/state-level reference model.
module tb_stopwatch_ctrl;
  localparam int DIV = 4;
  localparam int DB  = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

  logic        CLK = 1'b0;
  logic        RESET, BTN_SS, BTN_LC;
  logic [15:0] DIGITS;
  logic        RUNNING, LAP, TICK;

  int total = 0, bad = 0, n_tick = 0;

  stopwatch_ctrl #(.TICK_DIV(DIV), .DB_CNT(DB)) dut (
    .CLK(CLK), .RESET(RESET), .BTN_SS(BTN_SS), .BTN_LC(BTN_LC),
    .DIGITS(DIGITS), .RUNNING(RUNNING), .LAP(LAP), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // reference model: time in centiseconds, debounce as "last DB synced samples all differ"
  int m_st = 0, m_t = 0, m_pc = 0, m_lap = 0;
  int m_s1 [2] = '{0, 0};
  int m_s2 [2] = '{0, 0};
  int m_stb[2] = '{0, 0};
  int m_ev [2] = '{0, 0};
  int m_win[2][DB];

  task automatic mreset();
    m_st = M_IDLE; m_t = 0; m_pc = 0; m_lap = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stb[b] = 0; m_ev[b] = 0;
      for (int k = 0; k < DB; k++) m_win[b][k] = 0;
    end
  endtask

  always @(posedge CLK or negedge RESET) begin
    int ess, elc, raw[2], all;
    if (!RESET) mreset();
    else begin
      ess = m_ev[0]; elc = m_ev[1];
      raw[0] = int'(BTN_SS); raw[1] = int'(BTN_LC);
      if (m_st == M_RUN || m_st == M_LAP) begin
        if (m_pc == DIV - 1) begin m_pc = 0; m_t = (m_t + 1) % 6000; end
        else m_pc++;
      end
      case (m_st)
        M_IDLE: if (ess != 0) m_st = M_RUN;
        M_RUN:  if (ess != 0) m_st = M_STOP; else if (elc != 0) begin m_st = M_LAP; m_lap = m_t; end
        M_LAP:  if (ess != 0) m_st = M_STOP; else if (elc != 0) m_st = M_RUN;
        default: if (ess != 0) m_st = M_RUN; else if (elc != 0) begin m_st = M_IDLE; m_t = 0; m_pc = 0; end
      endcase
      for (int b = 0; b < 2; b++) begin
        for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = m_s2[b];
        all = 1;
        for (int k = 0; k < DB; k++) if (m_win[b][k] == m_stb[b]) all = 0;
        m_ev[b] = 0;
        if (all != 0) begin m_stb[b] = m_s2[b]; m_ev[b] = m_s2[b]; end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic r;
    @(negedge CLK);
    r = (m_st == M_RUN || m_st == M_LAP);
    chk("digits",  {16'd0, DIGITS}, {16'd0, bcd(m_st == M_LAP ? m_lap : m_t)});
    chk("running", {31'd0, RUNNING}, {31'd0, r});
    chk("lap",     {31'd0, LAP}, {31'd0, m_st == M_LAP});
    chk("tick",    {31'd0, TICK}, {31'd0, r && m_pc == DIV - 1});
    if (TICK) n_tick++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic ss, input logic lc, input int hold, input int bnc);
    for (int i = 0; i < bnc; i++) begin
      if (ss) BTN_SS = 1'($urandom);
      if (lc) BTN_LC = 1'($urandom);
      step();
    end
    BTN_SS = ss; BTN_LC = lc;
    cyc(hold);
    BTN_SS = 1'b0; BTN_LC = 1'b0;
    cyc(8);
  endtask

  task automatic wait_t(input int target, input int bound, input int pcw);
    int n = 0;
    while (!(m_t == target && (pcw < 0 || m_pc == pcw)) && n < bound) begin step(); n++; end
    if (n >= bound) chk("wait_timeout", 32'(m_t), 32'(target));
  endtask

  initial begin
    int keep, n;
    RESET = 1'b0; BTN_SS = 1'b0; BTN_LC = 1'b0;
    // reset held while buttons wiggle
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      chk("rst_digits", {16'd0, DIGITS}, 32'd0);
      chk("rst_running", {31'd0, RUNNING}, 32'd0);
      chk("rst_lap", {31'd0, LAP}, 32'd0);
      chk("rst_tick", {31'd0, TICK}, 32'd0);
      BTN_SS = 1'($urandom); BTN_LC = 1'($urandom);
    end
    BTN_SS = 1'b0; BTN_LC = 1'b0;
    @(negedge CLK); RESET = 1'b1;

    // per-cycle toggling never debounces
    for (int i = 0; i < 8; i++) begin BTN_SS = ~BTN_SS; step(); end
    BTN_SS = 1'b0; cyc(12);
    chk("bounce_idle", {31'd0, RUNNING}, 32'd0);

    n_tick = 0;
    press(1'b1, 1'b0, 10, 0);
    chk("start_run", {31'd0, RUNNING}, 32'd1);
    wait_t(10, 200, -1);
    step();
    chk("ten_ticks", 32'(n_tick), 32'd10);
    chk("d0010", {16'd0, DIGITS}, 32'h0010);

    wait_t(5999, 30000, -1);
    step();
    chk("d5999", {16'd0, DIGITS}, 32'h5999);
    wait_t(0, 10, -1);
    step();
    chk("wrap0000", {16'd0, DIGITS}, 32'h0000);
    chk("wrap_running", {31'd0, RUNNING}, 32'd1);

    // LC raised just after a tick at 01.22 lands after one more tick
    wait_t(122, 2000, 0);
    n_tick = 0;
    press(1'b0, 1'b1, 10, 0);
    chk("lap_0123", {16'd0, DIGITS}, 32'h0123);
    chk("lap_flag", {31'd0, LAP}, 32'd1);
    cyc(20);
    chk("lap_frozen", {16'd0, DIGITS}, 32'h0123);
    chk("lap_ticking", 32'(n_tick > 4), 32'd1);
    press(1'b0, 1'b1, 10, 0);
    chk("lap_off", {31'd0, LAP}, 32'd0);
    chk("live_time", {16'd0, DIGITS}, {16'd0, bcd(m_t)});

    press(1'b1, 1'b0, 10, 1);
    chk("stop_running", {31'd0, RUNNING}, 32'd0);
    keep = m_t;
    cyc(40);
    chk("stop_hold", {16'd0, DIGITS}, {16'd0, bcd(keep)});
    press(1'b1, 1'b0, 10, 2);
    chk("resume", {31'd0, RUNNING}, 32'd1);
    cyc(20);
    press(1'b1, 1'b0, 10, 0);
    press(1'b0, 1'b1, 10, 0);
    chk("clear_digits", {16'd0, DIGITS}, 32'h0000);
    chk("clear_idle", {31'd0, RUNNING}, 32'd0);

    // simultaneous SS+LC from STOP: SS wins, time kept
    press(1'b1, 1'b0, 10, 0);
    cyc(30);
    press(1'b1, 1'b0, 10, 0);
    keep = m_t;
    BTN_SS = 1'b1; BTN_LC = 1'b1;
    n = 0;
    while (m_st != M_RUN && n < 20) begin step(); n++; end
    if (n >= 20) chk("both_timeout", 32'(m_st), 32'(M_RUN));
    chk("both_run", {31'd0, RUNNING}, 32'd1);
    chk("both_nolap", {31'd0, LAP}, 32'd0);
    chk("both_keep", {16'd0, DIGITS}, {16'd0, bcd(keep)});
    BTN_SS = 1'b0; BTN_LC = 1'b0;
    cyc(20);

    // async reset mid-run clears outputs without waiting for a clock edge
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("arst_digits", {16'd0, DIGITS}, 32'd0);
    chk("arst_running", {31'd0, RUNNING}, 32'd0);
    chk("arst_tick", {31'd0, TICK}, 32'd0);
    cyc(3);
    RESET = 1'b1;
    cyc(3);

    for (int i = 0; i < 200; i++) begin
      n = $urandom_range(1, 3);
      press(1'(n), 1'(n >> 1), $urandom_range(1, 12), $urandom_range(0, 3));
      cyc($urandom_range(0, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
